// File: rtl/mm2s_lite_wr_master_if.sv
// ---------------------------------------------------------------------------
// mm2s_lite_wr_master_if
//
// AXI4-Lite write-only bus between the MM2S register-write master and the
// DMA register slave. Read channels are not carried because the master
// only writes registers.
//
// Signals:
//   m_axi_awaddr / m_axi_awprot / m_axi_awvalid / m_axi_awready : AW channel
//   m_axi_wdata  / m_axi_wstrb  / m_axi_wvalid  / m_axi_wready  : W channel
//   m_axi_bresp  / m_axi_bvalid / m_axi_bready                  : B channel
//
// Modports:
//   master : drives AW/W payload and valids plus bready
//   slave  : drives awready, wready and the B response
// ---------------------------------------------------------------------------
interface mm2s_lite_wr_master_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wvalid;
  logic                m_axi_wready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_bvalid;
  logic                m_axi_bready;

  modport master (
    output m_axi_awaddr,
    output m_axi_awprot,
    output m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata,
    output m_axi_wstrb,
    output m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp,
    input  m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    input  m_axi_awaddr,
    input  m_axi_awprot,
    input  m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata,
    input  m_axi_wstrb,
    input  m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp,
    output m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/mm2s_lite_wr_master.sv
// ---------------------------------------------------------------------------
// mm2s_lite_wr_master
//
// Turns single register-write requests from the MM2S control FSM into one
// AXI4-Lite write transaction each, toward the DMA register slave, and
// reports completion with a one-cycle lite_end pulse. Only one transaction
// is ever outstanding; requests arriving while busy are ignored.
//
// Ports:
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset (released synchronously
//                  through an internal two-flop synchroniser)
//   lite_valid   : write request, sampled only while idle
//   lite_awaddr  : request byte address
//   lite_wdata   : request write data
//   lite_end     : one-cycle completion pulse
//   lite_err     : valid with lite_end; 1 when BRESP was SLVERR or DECERR
//   busy         : high from the cycle after accept through DONE
//   wr_count     : number of completed writes, wraps
//   axi          : AXI4-Lite write master (AW, W, B channels)
//
// Every AXI output comes straight from a flop, so no valid depends
// combinationally on a ready and no AXI input reaches an AXI output
// without a register in between.
// ---------------------------------------------------------------------------
module mm2s_lite_wr_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lite_valid,
  input  logic [ADDR_W-1:0]     lite_awaddr,
  input  logic [DATA_W-1:0]     lite_wdata,
  output logic                  lite_end,
  output logic                  lite_err,
  output logic                  busy,
  output logic [CNT_W-1:0]      wr_count,
  mm2s_lite_wr_master_if.master axi
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_DATA = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Reset synchroniser: assertion is immediate, release is aligned to clk so
  // every flop below leaves reset in the same cycle.
  // -------------------------------------------------------------------------
  logic rst_meta;
  logic rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta   <= 1'b0;
      rst_sync_n <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_sync_n <= rst_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Registered state and outputs
  // -------------------------------------------------------------------------
  state_t              state,       state_nxt;
  logic [ADDR_W-1:0]   awaddr_q,    awaddr_nxt;
  logic [DATA_W-1:0]   wdata_q,     wdata_nxt;
  logic                awvalid_q,   awvalid_nxt;
  logic                wvalid_q,    wvalid_nxt;
  logic                bready_q,    bready_nxt;
  logic                aw_done,     aw_done_nxt;
  logic                w_done,      w_done_nxt;
  logic                lite_end_q,  lite_end_nxt;
  logic                lite_err_q,  lite_err_nxt;
  logic                busy_q,      busy_nxt;
  logic [CNT_W-1:0]    wr_count_q,  wr_count_nxt;

  // Handshakes seen in the current cycle
  logic aw_hs;
  logic w_hs;
  logic resp_err;

  assign aw_hs    = awvalid_q & axi.m_axi_awready;
  assign w_hs     = wvalid_q  & axi.m_axi_wready;
  // SLVERR (2'b10) and DECERR (2'b11) both report failure; OKAY/EXOKAY do not.
  assign resp_err = (axi.m_axi_bresp == 2'b10) || (axi.m_axi_bresp == 2'b11);

  // -------------------------------------------------------------------------
  // State register (all state, including payload, clears on reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state      <= IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      lite_end_q <= 1'b0;
      lite_err_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state      <= state_nxt;
      awaddr_q   <= awaddr_nxt;
      wdata_q    <= wdata_nxt;
      awvalid_q  <= awvalid_nxt;
      wvalid_q   <= wvalid_nxt;
      bready_q   <= bready_nxt;
      aw_done    <= aw_done_nxt;
      w_done     <= w_done_nxt;
      lite_end_q <= lite_end_nxt;
      lite_err_q <= lite_err_nxt;
      busy_q     <= busy_nxt;
      wr_count_q <= wr_count_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    awaddr_nxt   = awaddr_q;
    wdata_nxt    = wdata_q;
    awvalid_nxt  = awvalid_q;
    wvalid_nxt   = wvalid_q;
    bready_nxt   = bready_q;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    lite_end_nxt = 1'b0;
    lite_err_nxt = lite_err_q;
    busy_nxt     = busy_q;
    wr_count_nxt = wr_count_q;

    unique case (state)
      IDLE: begin
        if (lite_valid) begin
          awaddr_nxt  = lite_awaddr;
          wdata_nxt   = lite_wdata;
          awvalid_nxt = 1'b1;
          wvalid_nxt  = 1'b1;
          busy_nxt    = 1'b1;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = ADDR_DATA;
        end
      end

      ADDR_DATA: begin
        // AW and W retire independently; each valid drops after its own beat.
        if (aw_hs) begin
          awvalid_nxt = 1'b0;
          aw_done_nxt = 1'b1;
        end
        if (w_hs) begin
          wvalid_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
        // bready is only raised here, so a bvalid that is already high when
        // the last beat completes is taken one cycle later, in WAIT_RESP.
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          bready_nxt  = 1'b1;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          state_nxt   = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        // bready is high throughout this state, so bvalid alone is the
        // B handshake.
        if (axi.m_axi_bvalid) begin
          bready_nxt   = 1'b0;
          lite_err_nxt = resp_err;
          lite_end_nxt = 1'b1;
          wr_count_nxt = wr_count_q + CNT_W'(1);
          state_nxt    = DONE;
        end
      end

      DONE: begin
        // lite_valid is deliberately not looked at here; the requester
        // gets one cycle after lite_end to retire or replace its request.
        busy_nxt     = 1'b0;
        lite_err_nxt = 1'b0;
        state_nxt    = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign axi.m_axi_awaddr  = awaddr_q;
  assign axi.m_axi_awprot  = 3'b000;
  assign axi.m_axi_awvalid = awvalid_q;
  assign axi.m_axi_wdata   = wdata_q;
  assign axi.m_axi_wstrb   = '1;
  assign axi.m_axi_wvalid  = wvalid_q;
  assign axi.m_axi_bready  = bready_q;

  assign lite_end = lite_end_q;
  assign lite_err = lite_err_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_mm2s_lite_wr_master.sv
// ---------------------------------------------------------------------------
// tb_mm2s_lite_wr_master
//
// Directed bench for mm2s_lite_wr_master. A small AXI4-Lite slave model
// with programmable AW/W ready delays drives the bus on the falling edge;
// a monitor logs every AW/W beat on the rising edge. Each test task drives
// its scenario and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mm2s_lite_wr_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lite_valid;
  logic [9:0]  lite_awaddr;
  logic [31:0] lite_wdata;
  logic        lite_end;
  logic        lite_err;
  logic        busy;
  logic [15:0] wr_count;

  mm2s_lite_wr_master_if #(.ADDR_W(10), .DATA_W(32)) axi ();

  mm2s_lite_wr_master #(.ADDR_W(10), .DATA_W(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lite_valid  (lite_valid),
    .lite_awaddr (lite_awaddr),
    .lite_wdata  (lite_wdata),
    .lite_end    (lite_end),
    .lite_err    (lite_err),
    .busy        (busy),
    .wr_count    (wr_count),
    .axi         (axi)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Slave configuration (written by tests only)
  int aw_delay = 0;
  int w_delay  = 0;
  bit b_early  = 1'b0;  // raise bvalid as soon as AW is done
  bit b_hold   = 1'b0;  // never raise bvalid

  // Monitor state (written by the posedge block only)
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int b_tot = 0, end_cnt = 0, stab_viol = 0, early_viol = 0;
  logic [9:0]  aw_log[$];
  logic [31:0] w_log[$];
  logic [3:0]  strb_log[$];
  logic        prev_awvalid = 1'b0;
  logic [9:0]  prev_awaddr  = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (axi.m_axi_awvalid && axi.m_axi_awready) begin
        aw_cnt++; aw_log.push_back(axi.m_axi_awaddr);
      end
      if (axi.m_axi_wvalid && axi.m_axi_wready) begin
        w_cnt++; w_log.push_back(axi.m_axi_wdata); strb_log.push_back(axi.m_axi_wstrb);
      end
      if (axi.m_axi_bvalid && axi.m_axi_bready) begin
        b_cnt++; b_tot++;
      end
      if (lite_end) end_cnt++;
      if (axi.m_axi_awvalid && prev_awvalid && axi.m_axi_awaddr != prev_awaddr) stab_viol++;
      if (axi.m_axi_bready && (axi.m_axi_awvalid || axi.m_axi_wvalid)) early_viol++;
    end
    prev_awvalid = axi.m_axi_awvalid;
    prev_awaddr  = axi.m_axi_awaddr;
  end

  // Slave model: ready/valid driven on the falling edge
  int aw_wait = 0, w_wait = 0;
  logic [1:0] cfg_bresp = 2'b00;

  always @(negedge clk) begin
    if (!rst_n) begin
      axi.m_axi_awready = 1'b0;
      axi.m_axi_wready  = 1'b0;
      axi.m_axi_bvalid  = 1'b0;
      axi.m_axi_bresp   = 2'b00;
      aw_wait = 0; w_wait = 0;
    end else begin
      if (axi.m_axi_awvalid) begin
        axi.m_axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        axi.m_axi_awready = 1'b0; aw_wait = 0;
      end
      if (axi.m_axi_wvalid) begin
        axi.m_axi_wready = (w_wait >= w_delay);
        w_wait++;
      end else begin
        axi.m_axi_wready = 1'b0; w_wait = 0;
      end
      axi.m_axi_bvalid = !b_hold && (b_early ? (aw_cnt > b_cnt)
                                             : (aw_cnt > b_cnt && w_cnt > b_cnt));
      axi.m_axi_bresp  = cfg_bresp;
    end
  end

  // Present one request (called at a falling edge) and wait for lite_end.
  task automatic issue(input logic [9:0] a, input logic [31:0] d, input bit keep,
                       output int lat, output logic err);
    bit got;
    lite_awaddr = a; lite_wdata = d; lite_valid = 1'b1;
    lat = 0; got = 1'b0;
    while (lat < 60 && !got) begin
      @(negedge clk); lat++;
      got = lite_end;
    end
    err = lite_err;
    if (!keep) lite_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lite_valid = 1'b0; lite_awaddr = '0; lite_wdata = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (axi.m_axi_awvalid !== 1'b0) begin n_fail++; $display("FAIL reset_awvalid: got %0b want 0", axi.m_axi_awvalid); end
    n_cmp++; if (axi.m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %0b want 0", axi.m_axi_wvalid); end
    n_cmp++; if (axi.m_axi_bready !== 1'b0) begin n_fail++; $display("FAIL reset_bready: got %0b want 0", axi.m_axi_bready); end
    n_cmp++; if (lite_end !== 1'b0) begin n_fail++; $display("FAIL reset_lite_end: got %0b want 0", lite_end); end
    n_cmp++; if (lite_err !== 1'b0) begin n_fail++; $display("FAIL reset_lite_err: got %0b want 0", lite_err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    n_cmp++; if (axi.m_axi_awaddr !== 10'h000) begin n_fail++; $display("FAIL reset_awaddr: got %h want 000", axi.m_axi_awaddr); end
    n_cmp++; if (axi.m_axi_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", axi.m_axi_wdata); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %0b want 0", busy); end
    n_cmp++; if (axi.m_axi_awprot !== 3'b000) begin n_fail++; $display("FAIL awprot: got %b want 000", axi.m_axi_awprot); end
    n_cmp++; if (axi.m_axi_wstrb !== 4'hF) begin n_fail++; $display("FAIL wstrb_const: got %h want f", axi.m_axi_wstrb); end
  endtask

  task automatic test_zero_wait();
    int lat, n0, e0;
    aw_delay = 0; w_delay = 0; b_early = 0; b_hold = 0; cfg_bresp = 2'b00;
    n0 = aw_log.size(); e0 = end_cnt;
    lite_awaddr = 10'h018; lite_wdata = 32'h1000_0000; lite_valid = 1'b1;
    @(negedge clk);
    lite_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zw_busy: got %0b want 1", busy); end
    n_cmp++; if (axi.m_axi_awvalid !== 1'b1) begin n_fail++; $display("FAIL zw_awvalid: got %0b want 1", axi.m_axi_awvalid); end
    n_cmp++; if (axi.m_axi_wvalid !== 1'b1) begin n_fail++; $display("FAIL zw_wvalid: got %0b want 1", axi.m_axi_wvalid); end
    n_cmp++; if (axi.m_axi_awaddr !== 10'h018) begin n_fail++; $display("FAIL zw_awaddr: got %h want 018", axi.m_axi_awaddr); end
    lat = 1;
    while (lat < 40 && lite_end !== 1'b1) begin @(negedge clk); lat++; end
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL zw_latency: got %0d want 3", lat); end
    n_cmp++; if (lite_err !== 1'b0) begin n_fail++; $display("FAIL zw_lite_err: got %0b want 0", lite_err); end
    @(negedge clk);
    n_cmp++; if (lite_end !== 1'b0) begin n_fail++; $display("FAIL zw_end_pulse: got %0b want 0", lite_end); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy_after: got %0b want 0", busy); end
    n_cmp++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL zw_wr_count: got %0d want 1", wr_count); end
    n_cmp++; if (aw_log.size() - n0 != 1) begin n_fail++; $display("FAIL zw_aw_beats: got %0d want 1", aw_log.size() - n0); end
    else begin
      n_cmp++; if (aw_log[n0] !== 10'h018) begin n_fail++; $display("FAIL zw_aw_addr: got %h want 018", aw_log[n0]); end
      n_cmp++; if (w_log[n0] !== 32'h1000_0000) begin n_fail++; $display("FAIL zw_w_data: got %h want 10000000", w_log[n0]); end
      n_cmp++; if (strb_log[n0] !== 4'hF) begin n_fail++; $display("FAIL zw_w_strb: got %h want f", strb_log[n0]); end
    end
    n_cmp++; if (end_cnt - e0 != 1) begin n_fail++; $display("FAIL zw_end_count: got %0d want 1", end_cnt - e0); end
  endtask

  task automatic test_aw_delay();
    int lat, n0, m0, e0, s0, v0;
    logic err;
    aw_delay = 5; w_delay = 0; b_early = 0; cfg_bresp = 2'b00;
    n0 = aw_log.size(); m0 = w_log.size(); e0 = end_cnt; s0 = stab_viol; v0 = early_viol;
    issue(10'h028, 32'h0000_0400, 1'b0, lat, err);
    n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL awd_latency: got %0d want 8", lat); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL awd_lite_err: got %0b want 0", err); end
    @(negedge clk);
    n_cmp++; if (aw_log.size() - n0 != 1) begin n_fail++; $display("FAIL awd_aw_beats: got %0d want 1", aw_log.size() - n0); end
    n_cmp++; if (w_log.size() - m0 != 1) begin n_fail++; $display("FAIL awd_w_beats: got %0d want 1", w_log.size() - m0); end
    if (aw_log.size() > n0) begin
      n_cmp++; if (aw_log[n0] !== 10'h028) begin n_fail++; $display("FAIL awd_aw_addr: got %h want 028", aw_log[n0]); end
    end
    if (w_log.size() > m0) begin
      n_cmp++; if (w_log[m0] !== 32'h0000_0400) begin n_fail++; $display("FAIL awd_w_data: got %h want 00000400", w_log[m0]); end
    end
    n_cmp++; if (stab_viol != s0) begin n_fail++; $display("FAIL awd_addr_stable: got %0d changes want 0", stab_viol - s0); end
    n_cmp++; if (early_viol != v0) begin n_fail++; $display("FAIL awd_bready_early: got %0d want 0", early_viol - v0); end
    n_cmp++; if (end_cnt - e0 != 1) begin n_fail++; $display("FAIL awd_end_count: got %0d want 1", end_cnt - e0); end
  endtask

  task automatic test_w_delay();
    int lat, n0, m0, b0, v0;
    logic err;
    // W late, B raised early: the response must wait for bready.
    aw_delay = 0; w_delay = 3; b_early = 1; cfg_bresp = 2'b00;
    n0 = aw_log.size(); m0 = w_log.size(); b0 = b_tot; v0 = early_viol;
    issue(10'h004, 32'hABCD_0123, 1'b0, lat, err);
    n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL wd_latency: got %0d want 6", lat); end
    @(negedge clk);
    n_cmp++; if (b_tot - b0 != 1) begin n_fail++; $display("FAIL wd_b_beats: got %0d want 1", b_tot - b0); end
    n_cmp++; if (w_log.size() - m0 != 1) begin n_fail++; $display("FAIL wd_w_beats: got %0d want 1", w_log.size() - m0); end
    n_cmp++; if (early_viol != v0) begin n_fail++; $display("FAIL wd_bready_early: got %0d want 0", early_viol - v0); end
    // AW and W accepted in the same cycle.
    aw_delay = 2; w_delay = 2; b_early = 0;
    n0 = aw_log.size(); m0 = w_log.size();
    issue(10'h01C, 32'h0000_00C3, 1'b0, lat, err);
    n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL same_latency: got %0d want 5", lat); end
    @(negedge clk);
    n_cmp++; if (aw_log.size() - n0 != 1) begin n_fail++; $display("FAIL same_aw_beats: got %0d want 1", aw_log.size() - n0); end
    n_cmp++; if (w_log.size() - m0 != 1) begin n_fail++; $display("FAIL same_w_beats: got %0d want 1", w_log.size() - m0); end
    if (w_log.size() > m0) begin
      n_cmp++; if (w_log[m0] !== 32'h0000_00C3) begin n_fail++; $display("FAIL same_w_data: got %h want 000000c3", w_log[m0]); end
    end
  endtask

  task automatic test_bresp_err();
    int lat;
    logic err;
    aw_delay = 0; w_delay = 0; b_early = 0;
    cfg_bresp = 2'b10;
    issue(10'h000, 32'h0000_0001, 1'b0, lat, err);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL slverr_lite_err: got %0b want 1", err); end
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL slverr_latency: got %0d want 3", lat); end
    @(negedge clk);
    n_cmp++; if (lite_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_idle: got %0b want 0", lite_err); end
    cfg_bresp = 2'b00;
    issue(10'h000, 32'h0000_0002, 1'b0, lat, err);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL okay_lite_err: got %0b want 0", err); end
    @(negedge clk);
    cfg_bresp = 2'b11;
    issue(10'h004, 32'h0000_0003, 1'b0, lat, err);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL decerr_lite_err: got %0b want 1", err); end
    @(negedge clk);
    cfg_bresp = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [9:0]  addr [5] = '{10'h000, 10'h018, 10'h01C, 10'h028, 10'h004};
    logic [31:0] data [5] = '{32'h0000_0001, 32'h2000_0000, 32'h0000_0000,
                              32'h0000_0100, 32'hFFFF_FFFF};
    int lat, n0, m0;
    logic err;
    logic [15:0] c0;
    aw_delay = 0; w_delay = 0; b_early = 0; cfg_bresp = 2'b00;
    n0 = aw_log.size(); m0 = w_log.size(); c0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      issue(addr[i], data[i], (i < 4), lat, err);
      n_cmp++; if (lat != ((i == 0) ? 3 : 4)) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", i, lat, (i == 0) ? 3 : 4); end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (aw_log.size() - n0 != 5) begin n_fail++; $display("FAIL b2b_aw_beats: got %0d want 5", aw_log.size() - n0); end
    n_cmp++; if (w_log.size() - m0 != 5) begin n_fail++; $display("FAIL b2b_w_beats: got %0d want 5", w_log.size() - m0); end
    n_cmp++; if (wr_count - c0 != 16'd5) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want 5", wr_count - c0); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %0b want 0", busy); end
    for (int i = 0; i < 5; i++) begin
      if (n0 + i < aw_log.size()) begin
        n_cmp++; if (aw_log[n0+i] !== addr[i]) begin n_fail++; $display("FAIL b2b_aw_addr[%0d]: got %h want %h", i, aw_log[n0+i], addr[i]); end
      end
      if (m0 + i < w_log.size()) begin
        n_cmp++; if (w_log[m0+i] !== data[i]) begin n_fail++; $display("FAIL b2b_w_data[%0d]: got %h want %h", i, w_log[m0+i], data[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k, lat, e0;
    logic err;
    aw_delay = 0; w_delay = 0; b_early = 0; b_hold = 1; cfg_bresp = 2'b00;
    e0 = end_cnt;
    lite_awaddr = 10'h028; lite_wdata = 32'h0000_0800; lite_valid = 1'b1;
    k = 0;
    @(negedge clk);
    lite_valid = 1'b0;
    while (k < 20 && axi.m_axi_bready !== 1'b1) begin @(negedge clk); k++; end
    n_cmp++; if (axi.m_axi_bready !== 1'b1) begin n_fail++; $display("FAIL rm_reach_wait_resp: got bready %0b want 1", axi.m_axi_bready); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (axi.m_axi_awvalid !== 1'b0 || axi.m_axi_wvalid !== 1'b0) begin n_fail++; $display("FAIL rm_valids: got aw %0b w %0b want 0 0", axi.m_axi_awvalid, axi.m_axi_wvalid); end
    n_cmp++; if (axi.m_axi_bready !== 1'b0) begin n_fail++; $display("FAIL rm_bready: got %0b want 0", axi.m_axi_bready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %0b want 0", busy); end
    n_cmp++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL rm_wr_count: got %0d want 0", wr_count); end
    n_cmp++; if (axi.m_axi_awaddr !== 10'h000) begin n_fail++; $display("FAIL rm_awaddr: got %h want 000", axi.m_axi_awaddr); end
    repeat (2) @(negedge clk);
    b_hold = 0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (end_cnt != e0) begin n_fail++; $display("FAIL rm_no_lite_end: got %0d want 0", end_cnt - e0); end
    issue(10'h018, 32'h0000_0055, 1'b0, lat, err);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL rm_new_latency: got %0d want 3", lat); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rm_new_err: got %0b want 0", err); end
    @(negedge clk);
    n_cmp++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL rm_new_wr_count: got %0d want 1", wr_count); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_aw_delay();
    test_w_delay();
    test_bresp_err();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mm2s_lite_wr_master.md
Name: mm2s_lite_wr_master

Overview:
- Responder side of the MM2S register-programming interface: accepts single register-write requests (lite_valid/lite_awaddr/lite_wdata) from the MM2S control FSM.
- Performs each as one AXI4-Lite write transaction toward the DMA register slave, then returns a one-cycle lite_end completion pulse.
- Sits between the control FSM and the DMA's AXI4-Lite slave port; one transaction outstanding at a time.

Parameters:
- ADDR_W, 10, address width of request and AXI AW channel.
- DATA_W, 32, data width of request and AXI W channel.
- CNT_W, 16, width of the completed-write counter.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- lite_valid  input  1  write request; sampled only in IDLE.
- lite_awaddr  input  ADDR_W  request byte address.
- lite_wdata  input  DATA_W  request write data.
- lite_end  output  1  one-cycle pulse: transaction complete.
- lite_err  output  1  valid with lite_end; 1 = BRESP was SLVERR/DECERR.
- busy  output  1  high from request accept to DONE inclusive.
- wr_count  output  CNT_W  number of completed writes; wraps.
- m_axi_awaddr  output  ADDR_W  AW address.
- m_axi_awprot  output  3  constant 3'b000.
- m_axi_awvalid  output  1  AW valid.
- m_axi_awready  input  1  AW ready.
- m_axi_wdata  output  DATA_W  W data.
- m_axi_wstrb  output  DATA_W/8  constant all ones.
- m_axi_wvalid  output  1  W valid.
- m_axi_wready  input  1  W ready.
- m_axi_bresp  input  2  write response.
- m_axi_bvalid  input  1  B valid.
- m_axi_bready  output  1  B ready.

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE; all outputs 0 (awvalid, wvalid, bready, lite_end, lite_err, busy, wr_count, awaddr, wdata).
- States: IDLE, ADDR_DATA, WAIT_RESP, DONE.
- IDLE: if lite_valid=1, register lite_awaddr/lite_wdata into m_axi_awaddr/m_axi_wdata. Next cycle set awvalid=1, wvalid=1, busy=1, and go to ADDR_DATA.
- ADDR_DATA: AW and W complete independently.
  - awvalid drops the cycle after the awvalid&awready handshake; wvalid drops the cycle after wvalid&wready.
  - Handshakes may occur in the same cycle or in either order.
  - awaddr and wdata stay stable while their valid is high.
  - When both handshakes are done (tracked by aw_done/w_done flags), go to WAIT_RESP with bready=1.
  - If the last of the two handshakes completes in the same cycle bvalid is already high, the response is not taken that cycle; bready rises first.
- WAIT_RESP: bready=1. On bvalid=1: bready drops, lite_err <= bresp[1], go to DONE.
- DONE (exactly one cycle): lite_end=1; lite_err holds the captured value; wr_count increments (wraps 2^CNT_W-1 -> 0); next state IDLE.
  - lite_valid is ignored in DONE. The requester must drop lite_valid or present the next request by the cycle after lite_end.
  - lite_err clears on IDLE entry.
- Valid never depends combinationally on ready. No combinational path from any AXI input to any AXI output.
- Throughput: minimum 4 cycles per write (accept, AW/W, B, DONE) with zero-wait slave.
- lite_valid while busy (ADDR_DATA/WAIT_RESP/DONE): ignored; no queueing.
- Reset mid-transaction: all valids/bready drop immediately, state IDLE, no lite_end. wr_count resets to 0.
- bvalid while not in WAIT_RESP: ignored (bready=0).

Test Plan:
- Zero-wait slave (awready=wready=1, bvalid one cycle after both handshakes, bresp=00), request addr=0x018 data=0x1000_0000 -> AXI write to 0x018 with 0x1000_0000, wstrb=4'hF. lite_end pulses 1 cycle, lite_err=0, wr_count=1.
- awready delayed 5 cycles, wready immediate; addr=0x028 data=0x0000_0400 -> wvalid drops after its handshake. awvalid held with stable awaddr until handshake. bready rises only after AW completes. Single lite_end.
- wready delayed 3 cycles, awready immediate; also the case with both handshakes in the same cycle -> exactly one AW and one W beat each, then correct B handling, one lite_end.
- bresp=2'b10 on a write to 0x000 -> lite_err=1 coincident with lite_end; next write with bresp=00 -> lite_err=0.
- Five back-to-back requests (DMACR 0x000, SA 0x018, MSB 0x01C, LENGTH 0x028, DMASR 0x004), lite_valid held high through lite_end -> exactly five transactions in order, no double accept, wr_count=5.
- rst_n asserted while in WAIT_RESP -> outputs 0 asynchronously, no lite_end. After release, a new request completes normally with wr_count=1.
